// File: rtl/ram_dual_port.sv
// ram_dual_port: simple-dual-port synchronous RAM with one write port and one
// read port, registered read data with a one-cycle valid strobe, selectable
// same-address collision behaviour, and a clear engine that sweeps zeros
// through the whole array one word per cycle.
//
// Handshake: there is no backpressure. write_enable and read_enable are
// single-cycle requests sampled on the rising edge; read_valid is a one-cycle
// strobe in the cycle after an accepted read. While busy=1 both requests are
// dropped (not stalled), so callers must wait for busy=0 before issuing.
module ram_dual_port #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int WRITE_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  debug_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clear_count;
  logic [ADDR_WIDTH-1:0] clear_count_next;

  logic                  user_write;
  logic                  user_read;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  collision;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Next-state logic for the clear engine and the shared write-port mux.
  always_comb begin
    state_next       = state;
    clear_count_next = clear_count;
    user_write       = 1'b0;
    user_read        = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = write_address;
    mem_wdata        = write_data;

    case (state)
      IDLE: begin
        // clear_start takes priority: a write in the same cycle is dropped.
        user_write = write_enable && !clear_start;
        user_read  = read_enable;
        if (clear_start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        mem_addr         = clear_count;
        mem_wdata        = '0;
        clear_count_next = clear_count + 1'b1;
        // All-ones count means the last word is being zeroed this cycle.
        if (&clear_count) begin
          state_next       = IDLE;
          clear_count_next = '0;
        end
      end
      default: begin
        state_next       = IDLE;
        clear_count_next = '0;
      end
    endcase

    // Reset blocks any array write on its edge so a mid-clear reset leaves the
    // not-yet-swept words untouched.
    mem_we = !reset && ((state == CLEAR) || user_write);
  end

  assign collision   = user_write && (write_address == read_address);
  assign busy        = (state == CLEAR);
  assign debug_state = state;

  // FSM state and sweep counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clear_count <= '0;
    end else begin
      state       <= state_next;
      clear_count <= clear_count_next;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Registered read port; read_data holds between accepted reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= user_read;
      if (user_read) begin
        if ((WRITE_FIRST != 0) && collision) begin
          read_data <= write_data;
        end else begin
          read_data <= mem[read_address];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_dual_port.sv
// Testbench for ram_dual_port: two 16x8 instances (read-first and
// write-first) share one stimulus stream, plus a 64x32 instance for the wide
// parameter set.
module tb_ram_dual_port;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 16x8 instances (shared inputs) ----------------
  logic       we, re, cs;
  logic [3:0] wa, ra;
  logic [7:0] wd;
  logic [7:0] rd0, rd1;
  logic       rv0, rv1, busy0, busy1, st0, st1;

  ram_dual_port #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WRITE_FIRST(0)) dut_rf (
    .clk(clk), .reset(reset),
    .write_enable(we), .write_address(wa), .write_data(wd),
    .read_enable(re), .read_address(ra),
    .read_data(rd0), .read_valid(rv0),
    .clear_start(cs), .busy(busy0), .debug_state(st0)
  );

  ram_dual_port #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WRITE_FIRST(1)) dut_wf (
    .clk(clk), .reset(reset),
    .write_enable(we), .write_address(wa), .write_data(wd),
    .read_enable(re), .read_address(ra),
    .read_data(rd1), .read_valid(rv1),
    .clear_start(cs), .busy(busy1), .debug_state(st1)
  );

  // ---------------- 64x32 instance ----------------
  logic        w_we, w_re, w_cs;
  logic [5:0]  w_wa, w_ra;
  logic [31:0] w_wd, w_rd;
  logic        w_rv, w_busy, w_st;

  ram_dual_port #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WRITE_FIRST(0)) dut_wide (
    .clk(clk), .reset(reset),
    .write_enable(w_we), .write_address(w_wa), .write_data(w_wd),
    .read_enable(w_re), .read_address(w_ra),
    .read_data(w_rd), .read_valid(w_rv),
    .clear_start(w_cs), .busy(w_busy), .debug_state(w_st)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; cs = 1'b0;
    wa = '0; ra = '0; wd = '0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wa = 4'(i); wd = v;
      tick();
    end
    we = 1'b0;
  endtask

  // Back-to-back reads of all 16 words, compared against exp_q in order.
  task automatic read_all_check(input string name);
    logic [31:0] e;
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; ra = 4'(i);
      tick();
      e = exp_q.pop_front();
      check({name, "_valid"}, {30'd0, rv1, rv0}, 32'h3);
      check({name, "_rf"}, {24'd0, rd0}, e);
      check({name, "_wf"}, {24'd0, rd1}, e);
    end
    re = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic       ev;
    logic [7:0] ed_rf;
    logic [7:0] ed_wf;
  } vec_t;

  vec_t vecs[10];
  int   busy_cnt;

  initial begin
    //            we    wa     wd     re    ra     ev    ed_rf  ed_wf
    vecs[0] = '{1'b1, 4'd15, 8'h56, 1'b0, 4'd0,  1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 4'd6,  8'h36, 1'b0, 4'd0,  1'b0, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'h56, 8'h56};
    vecs[3] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd6,  1'b1, 8'h36, 8'h36};
    vecs[4] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'h36, 8'h36};
    vecs[5] = '{1'b1, 4'd3,  8'hAA, 1'b0, 4'd0,  1'b0, 8'h36, 8'h36};
    vecs[6] = '{1'b1, 4'd3,  8'h55, 1'b1, 4'd3,  1'b1, 8'hAA, 8'h55};
    vecs[7] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  1'b1, 8'h55, 8'h55};
    vecs[8] = '{1'b1, 4'd9,  8'h11, 1'b1, 4'd6,  1'b1, 8'h36, 8'h36};
    vecs[9] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd9,  1'b1, 8'h11, 8'h11};

    idle_inputs();
    w_we = 1'b0; w_re = 1'b0; w_cs = 1'b0;
    w_wa = '0; w_ra = '0; w_wd = '0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("reset_rdata_rf", {24'd0, rd0}, 32'h0);
    check("reset_rdata_wf", {24'd0, rd1}, 32'h0);
    check("reset_rvalid", {29'd0, w_rv, rv1, rv0}, 32'h0);
    check("reset_busy", {29'd0, w_busy, busy1, busy0}, 32'h0);
    check("reset_rdata_wide", w_rd, 32'h0);
    reset = 1'b0;

    // Table-driven write/read/collision vectors
    for (int i = 0; i < 10; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      re = vecs[i].re; ra = vecs[i].ra;
      tick();
      check($sformatf("vec%0d_valid_rf", i), {31'd0, rv0}, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d_valid_wf", i), {31'd0, rv1}, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d_data_rf", i), {24'd0, rd0}, {24'd0, vecs[i].ed_rf});
      check($sformatf("vec%0d_data_wf", i), {24'd0, rd1}, {24'd0, vecs[i].ed_wf});
    end
    idle_inputs();

    // Clear sweep: writes/reads ignored while busy, second clear_start ignored
    fill(8'hFF);
    cs = 1'b1;
    tick();
    cs = 1'b0;
    check("clear_busy_start", {30'd0, busy1, busy0}, 32'h3);
    busy_cnt = 0;
    while (busy0 && busy_cnt < 40) begin
      busy_cnt++;
      we = 1'b1; wa = 4'd2; wd = 8'h12;
      re = 1'b1; ra = 4'd2;
      cs = (busy_cnt == 8);
      tick();
      check("clear_no_rvalid", {30'd0, rv1, rv0}, 32'h0);
    end
    idle_inputs();
    check("clear_busy_len", busy_cnt, 32'd16);
    check("clear_busy_end_wf", {31'd0, busy1}, 32'h0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h00);
    read_all_check("clear_read");

    // Clear wins over a same-cycle write; reset in the 5th busy cycle
    fill(8'hFF);
    cs = 1'b1; we = 1'b1; wa = 4'd5; wd = 8'h77;
    tick();
    idle_inputs();
    repeat (4) tick();
    check("midclear_still_busy", {30'd0, busy1, busy0}, 32'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midclear_busy_drop", {30'd0, busy1, busy0}, 32'h0);
    check("midclear_rvalid", {30'd0, rv1, rv0}, 32'h0);
    for (int i = 0; i < 16; i++) exp_q.push_back((i < 4) ? 32'h00 : 32'hFF);
    read_all_check("midclear_read");

    // Fresh sweep restarts at address 0 and drops the same-cycle write
    cs = 1'b1; we = 1'b1; wa = 4'd5; wd = 8'h77;
    tick();
    idle_inputs();
    busy_cnt = 0;
    while (busy0 && busy_cnt < 40) begin
      busy_cnt++;
      tick();
    end
    check("restart_busy_len", busy_cnt, 32'd16);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h00);
    read_all_check("restart_read");

    // Wide instance: 64 writes then 64 back-to-back reads
    for (int i = 0; i < 64; i++) begin
      w_we = 1'b1; w_wa = 6'(i); w_wd = 32'hA5A50000 + 32'(i);
      tick();
    end
    w_we = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w_re = 1'b1; w_ra = 6'(i);
      tick();
      check("wide_valid", {31'd0, w_rv}, 32'h1);
      check("wide_data", w_rd, 32'hA5A50000 + 32'(i));
    end
    w_re = 1'b0;
    tick();
    check("wide_valid_drop", {31'd0, w_rv}, 32'h0);
    check("wide_data_hold", w_rd, 32'hA5A5003F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
